jam_rr_scheduler: RTL and testbench
===================================

// Module: jam_rr_scheduler
// PURPOSE
// - Parametrised round-robin jam-mode lane scheduler for the traffic controller. Generalises the 4-lane jam unit to NUM_LANES.
// - Adds a per-grant green timer that enforces minimum and maximum green times, and an all-red clearance interval between grants.
// - Sits between the jam detectors and the light driver. Active only while the top-level FSM holds jam_op_en.
// PARAMETERS
// - NUM_LANES    4   number of lanes (>=2)
// - TMR_W        8   green/clear timer width, bits
// - MIN_GREEN    4   cycles a grant must be held before it may rotate (>=1)
// - MAX_GREEN   32   cycles after which a grant is forced to rotate (>MIN_GREEN, <2**TMR_W)
// - CLEAR_CYC    2   all-red cycles between grants (>=1, <2**TMR_W)
// PORTS
// - clk           in   1                     single clock, rising edge
// - rst           in   1                     reset; one clock; reset is synchronous and active-high
// - jam_op_en     in   1                     jam mode enable; low forces IDLE
// - jam_start     in   1                     pulse; starts scheduling from IDLE
// - jam_rotation  in   1                     rotation request from top FSM
// - traffic_jam   in   NUM_LANES             per-lane jam flag, bit i = lane i
// - allow_jam     out  NUM_LANES             one-hot green grant, or all zero
// - cur_lane      out  $clog2(NUM_LANES)     index of last/current granted lane
// - grant_vld     out  1                     high while in GREEN
// - grant_chg     out  1                     one-cycle pulse on the first GREEN cycle of each grant
// BEHAVIOUR
// - All outputs are registered. Reset values: allow_jam=0, cur_lane=0, grant_vld=0, grant_chg=0, state=IDLE, timer=0.
// - FSM states: IDLE, GREEN, CLEAR. rst has top priority; !jam_op_en is next. Either one forces IDLE with all outputs 0 and cur_lane=0 at the next edge, from any state.
// - IDLE: if jam_start and |traffic_jam, grant the lowest-index set lane and enter GREEN with timer=0. allow_jam is visible one cycle after jam_start is sampled.
// - IDLE with jam_start and no jam flag set: stay in IDLE.
// - GREEN:
//   - timer increments each cycle and saturates at MAX_GREEN-1.
//   - Exit to CLEAR at the next edge when any of these holds:
//     - (a) jam_rotation && timer>=MIN_GREEN-1
//     - (b) timer==MAX_GREEN-1
//     - (c) !traffic_jam[cur_lane] && timer>=MIN_GREEN-1
//   - jam_rotation before the minimum green time is dropped. It is not queued.
//   - jam_start is ignored in GREEN and CLEAR.
// - CLEAR: allow_jam=0, grant_vld=0, cur_lane held. Lasts exactly CLEAR_CYC cycles. In the last CLEAR cycle, sample traffic_jam:
//   - Next lane = first set bit searching cur_lane+1 upward, wrapping modulo NUM_LANES.
//   - cur_lane itself is considered last, so it may be re-granted only if it is the sole requester.
//   - No bit set: go to IDLE.
// - grant_chg pulses together with the first cycle of each new allow_jam one-hot, including a re-grant of the same lane.
// - Invariant: popcount(allow_jam)<=1 in every cycle. allow_jam!=0 iff grant_vld.
// - Mid-grant changes in traffic_jam never alter allow_jam directly. They act only through rule (c) or through selection in CLEAR.
// STRUCTURE
// - Package jam_pkg: state enum (IDLE/GREEN/CLEAR), lane-index width function, assertion helpers shared with the jam_op_unit benches.
// - Sub-module rr_lane_picker (combinational, parametrised NUM_LANES):
//   - Inputs: req vector, start offset.
//   - Outputs: found, index of first set bit at or after the offset, with wrap.
//   - Used for IDLE (offset 0) and CLEAR (offset cur_lane+1) selection.
// - Top module: FSM, timer, output registers.
// TESTING (NUM_LANES=4, MIN_GREEN=4, MAX_GREEN=8, CLEAR_CYC=2)
// - Reset: rst high 3 cycles with random inputs -> allow_jam=0000, cur_lane=0, grant_vld=0, grant_chg=0.
// - Start: traffic_jam=0110, pulse jam_start -> next cycle allow_jam=0010, cur_lane=1, grant_chg=1 for one cycle.
// - Min green: jam_rotation on GREEN cycle 2 -> ignored. On cycle 4 -> 2 cycles allow=0000, then allow=0100, cur_lane=2.
// - Max green: traffic_jam=0001 held, no rotation -> allow=0001 for 8 cycles, 2 clear cycles, then re-grant 0001 with grant_chg=1.
// - Wrap/empty: lane 3 granted, traffic_jam=1001, rotate -> allow=0001. Then traffic_jam=0000 at min green -> CLEAR, then IDLE, allow=0000.
// - Abort: drop jam_op_en mid-GREEN -> next cycle all outputs 0, IDLE. Assert rst mid-CLEAR -> IDLE, and jam_start then regrants from lane 0.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared types and helpers for the jam-mode lane scheduler and its benches.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: scheduler state enum, lane-index width helper, and small
// invariant helpers (popcount / at-most-one-hot) used by checkers.
package jam_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GREEN = 2'd1,
    CLEAR = 2'd2
  } jam_state_t;

  // Width of a lane index; never narrower than one bit.
  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned popcnt(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += {31'd0, v[i]};
    return c;
  endfunction

  function automatic logic onehot0_ok(input logic [31:0] v);
    return popcnt(v) <= 1;
  endfunction

endpackage

// File: rtl/rr_lane_picker.sv
// Round-robin lane picker: first set request bit at or after an offset, with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   req    in   NUM_LANES  request vector, bit i = lane i
//   offset in   LW         first lane index to consider
//   found  out  1          any request bit set
//   idx    out  LW         index of the selected lane (0 when !found)
module rr_lane_picker
  import jam_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LW        = lane_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LW-1:0]        offset,
  output logic                 found,
  output logic [LW-1:0]        idx
);

  // Walk the distances from farthest to nearest so the nearest set lane
  // is the last one written and therefore wins.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      j = int'(offset) + i;
      if (j >= NUM_LANES) j = j - NUM_LANES;
      if (req[j]) begin
        found = 1'b1;
        idx   = LW'(j);
      end
    end
  end

endmodule

// File: rtl/jam_rr_scheduler.sv
// Round-robin jam-mode lane scheduler with min/max green timing and all-red clearance.
// Latency: grant visible one cycle after jam_start is sampled; all outputs registered.
// Backpressure: none; jam_rotation before minimum green is dropped, not queued.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   jam_op_en     jam mode enable; low forces IDLE
//   jam_start     pulse, starts scheduling from IDLE
//   jam_rotation  rotation request from the top-level FSM
//   traffic_jam   per-lane jam flags
//   allow_jam     one-hot green grant, or zero
//   cur_lane      last/current granted lane
//   grant_vld     high while GREEN
//   grant_chg     pulse on the first GREEN cycle of each grant
module jam_rr_scheduler
  import jam_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int TMR_W     = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 32,
  parameter int CLEAR_CYC = 2,
  parameter int LW        = lane_w(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jam_op_en,
  input  logic                 jam_start,
  input  logic                 jam_rotation,
  input  logic [NUM_LANES-1:0] traffic_jam,
  output logic [NUM_LANES-1:0] allow_jam,
  output logic [LW-1:0]        cur_lane,
  output logic                 grant_vld,
  output logic                 grant_chg
);

  localparam logic [TMR_W-1:0] MIN_T = TMR_W'(MIN_GREEN - 1);
  localparam logic [TMR_W-1:0] MAX_T = TMR_W'(MAX_GREEN - 1);
  localparam logic [TMR_W-1:0] CLR_T = TMR_W'(CLEAR_CYC - 1);
  localparam logic [LW-1:0]    LAST  = LW'(NUM_LANES - 1);

  jam_state_t           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [LW-1:0]        cur_d;
  logic [NUM_LANES-1:0] allow_d;
  logic                 vld_d, chg_d;

  logic [LW-1:0]        pick_off;
  logic                 pick_found;
  logic [LW-1:0]        pick_idx;
  logic                 min_met;
  logic                 green_exit;

  // IDLE searches from lane 0; CLEAR searches from the lane after the
  // current one so the current lane is considered last.
  assign pick_off = (state_q == CLEAR) ? ((cur_lane == LAST) ? '0 : cur_lane + LW'(1)) : '0;

  rr_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .LW        (LW)
  ) u_picker (
    .req    (traffic_jam),
    .offset (pick_off),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign min_met    = (timer_q >= MIN_T);
  assign green_exit = (jam_rotation && min_met) || (timer_q == MAX_T) ||
                      (!traffic_jam[cur_lane] && min_met);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cur_d   = cur_lane;
    allow_d = allow_jam;
    vld_d   = grant_vld;
    chg_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (jam_start && pick_found) begin
          state_d = GREEN;
          timer_d = '0;
          cur_d   = pick_idx;
          allow_d = {{(NUM_LANES-1){1'b0}}, 1'b1} << pick_idx;
          vld_d   = 1'b1;
          chg_d   = 1'b1;
        end
      end
      GREEN: begin
        timer_d = (timer_q == MAX_T) ? timer_q : timer_q + TMR_W'(1);
        if (green_exit) begin
          state_d = CLEAR;
          timer_d = '0;
          allow_d = '0;
          vld_d   = 1'b0;
        end
      end
      CLEAR: begin
        if (timer_q == CLR_T) begin
          timer_d = '0;
          if (pick_found) begin
            state_d = GREEN;
            cur_d   = pick_idx;
            allow_d = {{(NUM_LANES-1){1'b0}}, 1'b1} << pick_idx;
            vld_d   = 1'b1;
            chg_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        allow_d = '0;
        vld_d   = 1'b0;
      end
    endcase

    if (!jam_op_en) begin
      state_d = IDLE;
      timer_d = '0;
      cur_d   = '0;
      allow_d = '0;
      vld_d   = 1'b0;
      chg_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cur_lane  <= '0;
      allow_jam <= '0;
      grant_vld <= 1'b0;
      grant_chg <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cur_lane  <= cur_d;
      allow_jam <= allow_d;
      grant_vld <= vld_d;
      grant_chg <= chg_d;
    end
  end

endmodule

// File: tb/tb_jam_rr_scheduler.sv
// Directed bench for jam_rr_scheduler (4 lanes, min green 4, max green 8, clear 2).
// Latency: n/a.
// Backpressure: n/a.
module tb_jam_rr_scheduler;
  import jam_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       jam_op_en;
  logic       jam_start;
  logic       jam_rotation;
  logic [3:0] traffic_jam;
  logic [3:0] allow_jam;
  logic [1:0] cur_lane;
  logic       grant_vld;
  logic       grant_chg;

  int vectors    = 0;
  int miscompares = 0;

  jam_rr_scheduler #(
    .NUM_LANES (4),
    .TMR_W     (8),
    .MIN_GREEN (4),
    .MAX_GREEN (8),
    .CLEAR_CYC (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jam_op_en    (jam_op_en),
    .jam_start    (jam_start),
    .jam_rotation (jam_rotation),
    .traffic_jam  (traffic_jam),
    .allow_jam    (allow_jam),
    .cur_lane     (cur_lane),
    .grant_vld    (grant_vld),
    .grant_chg    (grant_chg)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it; inputs set afterwards are
  // sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {allow_jam, cur_lane, grant_vld, grant_chg} and the
  // at-most-one-hot / allow-vs-valid invariant.
  task automatic chk(input string tag, input logic [3:0] a, input logic [1:0] l,
                     input logic v, input logic c);
    logic [7:0] obs, expv;
    logic       inv;
    obs  = {allow_jam, cur_lane, grant_vld, grant_chg};
    expv = {a, l, v, c};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed allow=%b lane=%0d vld=%b chg=%b, expected allow=%b lane=%0d vld=%b chg=%b",
             tag, obs[7:4], obs[3:2], obs[1], obs[0], a, l, v, c);
    end
    inv = onehot0_ok({28'd0, allow_jam}) && ((allow_jam != 4'd0) == grant_vld);
    vectors++;
    assert (inv === 1'b1) else begin
      miscompares++;
      $error("FAIL %s_inv: observed allow=%b vld=%b, expected at most one-hot with allow!=0 iff vld",
             tag, allow_jam, grant_vld);
    end
  endtask

  initial begin
    rst = 1'b1; jam_op_en = 1'b0; jam_start = 1'b0; jam_rotation = 1'b0; traffic_jam = 4'd0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      jam_op_en    = 1'($urandom_range(1, 0));
      jam_start    = 1'($urandom_range(1, 0));
      jam_rotation = 1'($urandom_range(1, 0));
      traffic_jam  = 4'($urandom_range(15, 0));
      tick();
      chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    rst = 1'b0; jam_op_en = 1'b1; jam_start = 1'b0; jam_rotation = 1'b0; traffic_jam = 4'd0;
    tick();
    chk("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Start: lowest set lane of 0110
    traffic_jam = 4'b0110; jam_start = 1'b1;
    tick(); chk("start", 4'b0010, 2'd1, 1'b1, 1'b1);
    jam_start = 1'b0;
    tick(); chk("green_c2", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Min green: rotation on cycle 2 dropped, on cycle 4 honoured
    jam_rotation = 1'b1;
    tick(); chk("rot_early_ignored", 4'b0010, 2'd1, 1'b1, 1'b0);
    jam_rotation = 1'b0;
    tick(); chk("green_c4", 4'b0010, 2'd1, 1'b1, 1'b0);
    jam_rotation = 1'b1;
    tick(); chk("clear1", 4'b0000, 2'd1, 1'b0, 1'b0);
    jam_rotation = 1'b0;
    tick(); chk("clear2", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick(); chk("rotate_to_2", 4'b0100, 2'd2, 1'b1, 1'b1);

    // Lane 2 drops its flag; only lane 0 remains
    traffic_jam = 4'b0001;
    tick(); tick(); tick();
    chk("lane2_c4", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); chk("clear_a", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick(); tick(); chk("wrap_to_0", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Max green: held 8 cycles, then clear, then re-grant of the same lane
    for (int i = 1; i < 8; i++) begin
      tick(); chk("max_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick(); chk("max_clear1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk("max_clear2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk("regrant_0", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Move to lane 3
    traffic_jam = 4'b1000;
    tick(); tick(); tick();
    tick(); tick();
    tick(); chk("grant_3", 4'b1000, 2'd3, 1'b1, 1'b1);

    // Wrap: from lane 3 with 1001, rotation picks lane 0
    traffic_jam = 4'b1001; jam_rotation = 1'b1;
    tick(); tick(); tick();
    chk("lane3_c4", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick(); jam_rotation = 1'b0;
    chk("wrap_clear", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick(); tick(); chk("wrap_grant_0", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Empty: all flags drop, clear then idle with cur_lane held
    traffic_jam = 4'b0000;
    tick(); tick(); tick();
    tick(); chk("empty_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); tick(); chk("empty_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // jam_start with no flags stays idle
    jam_start = 1'b1;
    tick(); chk("start_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Abort via jam_op_en mid-GREEN
    traffic_jam = 4'b0100;
    tick(); chk("start_2", 4'b0100, 2'd2, 1'b1, 1'b1);
    jam_start = 1'b0;
    tick();
    jam_op_en = 1'b0;
    tick(); chk("en_abort", 4'b0000, 2'd0, 1'b0, 1'b0);
    jam_op_en = 1'b1;
    tick(); chk("en_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset mid-CLEAR, then jam_start regrants from lane 0
    traffic_jam = 4'b0110; jam_start = 1'b1;
    tick(); chk("start_1b", 4'b0010, 2'd1, 1'b1, 1'b1);
    jam_start = 1'b0; traffic_jam = 4'b0000;
    tick(); tick(); tick();
    tick(); chk("pre_rst_clear", 4'b0000, 2'd1, 1'b0, 1'b0);
    rst = 1'b1; traffic_jam = 4'b1111;
    tick(); chk("rst_mid_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; jam_start = 1'b1;
    tick(); chk("post_rst_start", 4'b0001, 2'd0, 1'b1, 1'b1);
    jam_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
